// File: rtl/ac97_frame_tx_if.sv
// Sample and codec-command handshakes into the AC97 frame transmitter.
// master drives valid/data; slave (the transmitter) drives ready.
interface ac97_frame_tx_if;
    logic        I_SAMPLE_VALID;
    logic [19:0] I_LEFT;
    logic [19:0] I_RIGHT;
    logic        O_SAMPLE_READY;
    logic        I_CMD_VALID;
    logic [6:0]  I_CMD_ADDR;
    logic [15:0] I_CMD_DATA;
    logic        O_CMD_READY;

    modport master (
        output I_SAMPLE_VALID, I_LEFT, I_RIGHT,
        output I_CMD_VALID, I_CMD_ADDR, I_CMD_DATA,
        input  O_SAMPLE_READY, O_CMD_READY
    );

    modport slave (
        input  I_SAMPLE_VALID, I_LEFT, I_RIGHT,
        input  I_CMD_VALID, I_CMD_ADDR, I_CMD_DATA,
        output O_SAMPLE_READY, O_CMD_READY
    );
endinterface

// File: rtl/ac97_frame_tx.sv
// AC97 output-frame serializer: builds a 256-bit frame from one held PCM
// sample and one held register-write command, shifts it out on SDATA_OUT.
module ac97_frame_tx #(
    parameter int LEFT_SLOT  = 3,
    parameter int RIGHT_SLOT = 4
) (
    input  logic          I_BITCLK,
    input  logic          I_RESET_L,
    input  logic          I_ENABLE,
    ac97_frame_tx_if.slave bus,
    output logic          O_SYNC,
    output logic          O_SDATA_OUT,
    output logic          O_FRAME_START
);

    localparam int L_BASE = 16 + 20 * (LEFT_SLOT - 1);
    localparam int R_BASE = 16 + 20 * (RIGHT_SLOT - 1);
    localparam int C_BASE = 16;
    localparam int D_BASE = 36;

    logic [7:0]   bit_cnt;
    logic [7:0]   bit_nxt;
    logic         load;
    logic [255:0] frame;
    logic [255:0] frame_n;
    logic         sample_full;
    logic         cmd_full;
    logic [19:0]  left_q;
    logic [19:0]  right_q;
    logic [6:0]   addr_q;
    logic [15:0]  data_q;
    logic [19:0]  slot1_w;
    logic [19:0]  slot2_w;

    assign bit_nxt = bit_cnt + 8'd1;
    assign load    = (bit_cnt == 8'hFF);
    assign slot1_w = {1'b0, addr_q, 12'h000};
    assign slot2_w = {data_q, 4'h0};

    assign bus.O_SAMPLE_READY = ~sample_full;
    assign bus.O_CMD_READY    = ~cmd_full;

    // frame_n[k] is the bit sent at frame index k; slots go MSB first.
    always_comb begin
        frame_n = '0;
        if (sample_full) begin
            for (int j = 0; j < 20; j++) begin
                frame_n[L_BASE + j] = left_q[19 - j];
                frame_n[R_BASE + j] = right_q[19 - j];
            end
            frame_n[LEFT_SLOT]  = 1'b1;
            frame_n[RIGHT_SLOT] = 1'b1;
        end
        if (cmd_full) begin
            for (int j = 0; j < 20; j++) begin
                frame_n[C_BASE + j] = slot1_w[19 - j];
                frame_n[D_BASE + j] = slot2_w[19 - j];
            end
            frame_n[1] = 1'b1;
            frame_n[2] = 1'b1;
        end
        frame_n[0] = |frame_n[12:1];
    end

    always_ff @(posedge I_BITCLK or negedge I_RESET_L) begin
        if (!I_RESET_L) begin
            bit_cnt       <= 8'hFF;
            frame         <= '0;
            sample_full   <= 1'b0;
            cmd_full      <= 1'b0;
            left_q        <= '0;
            right_q       <= '0;
            addr_q        <= '0;
            data_q        <= '0;
            O_SYNC        <= 1'b0;
            O_SDATA_OUT   <= 1'b0;
            O_FRAME_START <= 1'b0;
        end else begin
            if (bus.I_SAMPLE_VALID && !sample_full) begin
                left_q      <= bus.I_LEFT;
                right_q     <= bus.I_RIGHT;
                sample_full <= 1'b1;
            end
            if (bus.I_CMD_VALID && !cmd_full) begin
                addr_q   <= bus.I_CMD_ADDR;
                data_q   <= bus.I_CMD_DATA;
                cmd_full <= 1'b1;
            end
            if (!I_ENABLE) begin
                bit_cnt       <= 8'hFF;
                O_SYNC        <= 1'b0;
                O_SDATA_OUT   <= 1'b0;
                O_FRAME_START <= 1'b0;
            end else begin
                bit_cnt       <= bit_nxt;
                O_SYNC        <= (bit_nxt < 8'd16);
                O_FRAME_START <= (bit_nxt == 8'd0);
                // A handshake on the load edge only sets a full flag that
                // was clear, so it lands in the following frame.
                if (load) begin
                    frame       <= frame_n;
                    O_SDATA_OUT <= frame_n[0];
                    if (sample_full) sample_full <= 1'b0;
                    if (cmd_full)    cmd_full    <= 1'b0;
                end else begin
                    O_SDATA_OUT <= frame[bit_nxt];
                end
            end
        end
    end

endmodule

// File: tb/tb_ac97_frame_tx.sv
// Self-checking bench for ac97_frame_tx: expected frames are queued when
// stimulus is driven and popped as whole frames are captured off SDATA_OUT.
module tb_ac97_frame_tx;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic sync;
    logic sdata;
    logic fstart;

    int checks = 0;
    int failures = 0;

    logic [255:0] exp_q[$];

    ac97_frame_tx_if bus();

    ac97_frame_tx #(.LEFT_SLOT(3), .RIGHT_SLOT(4)) dut (
        .I_BITCLK     (clk),
        .I_RESET_L    (rst_n),
        .I_ENABLE     (en),
        .bus          (bus),
        .O_SYNC       (sync),
        .O_SDATA_OUT  (sdata),
        .O_FRAME_START(fstart)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] put_slot(logic [255:0] f, int n,
                                              logic [19:0] v);
        logic [255:0] r;
        r = f;
        for (int j = 0; j < 20; j++) r[16 + 20 * (n - 1) + j] = v[19 - j];
        return r;
    endfunction

    function automatic logic [255:0] exp_frame(bit sv, logic [19:0] l,
                                               logic [19:0] r, bit cv,
                                               logic [6:0] a,
                                               logic [15:0] d);
        logic [255:0] f;
        f = '0;
        if (sv) begin
            f = put_slot(f, 3, l);
            f = put_slot(f, 4, r);
            f[3] = 1'b1;
            f[4] = 1'b1;
        end
        if (cv) begin
            f = put_slot(f, 1, {1'b0, a, 12'h000});
            f = put_slot(f, 2, {d, 4'h0});
            f[1] = 1'b1;
            f[2] = 1'b1;
        end
        f[0] = |f[12:1];
        return f;
    endfunction

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (fstart === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL frame_start_timeout got=none required=pulse");
        end
    endtask

    task automatic grab(input bit here, output logic [255:0] f,
                        output int nsync, output bit ok);
        f = '0;
        nsync = 0;
        if (here) ok = 1'b1;
        else wait_start(ok);
        if (ok) begin
            for (int i = 0; i < 256; i++) begin
                if (i > 0) @(negedge clk);
                f[i] = sdata;
                nsync = nsync + int'(sync);
            end
        end
    endtask

    task automatic send_sample(input logic [19:0] l, input logic [19:0] r);
        bus.I_SAMPLE_VALID = 1'b1;
        bus.I_LEFT = l;
        bus.I_RIGHT = r;
        @(negedge clk);
        bus.I_SAMPLE_VALID = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        en = 1'b0;
        bus.I_SAMPLE_VALID = 1'b0;
        bus.I_CMD_VALID = 1'b0;
        bus.I_LEFT = '0;
        bus.I_RIGHT = '0;
        bus.I_CMD_ADDR = '0;
        bus.I_CMD_DATA = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (sync !== 1'b0) begin
            failures++;
            $display("FAIL reset_sync got=%b required=0", sync);
        end
        checks++;
        if (sdata !== 1'b0) begin
            failures++;
            $display("FAIL reset_sdata got=%b required=0", sdata);
        end
        checks++;
        if (fstart !== 1'b0) begin
            failures++;
            $display("FAIL reset_fstart got=%b required=0", fstart);
        end
        checks++;
        if (bus.O_SAMPLE_READY !== 1'b1) begin
            failures++;
            $display("FAIL reset_sready got=%b required=1",
                     bus.O_SAMPLE_READY);
        end
        checks++;
        if (bus.O_CMD_READY !== 1'b1) begin
            failures++;
            $display("FAIL reset_cready got=%b required=1", bus.O_CMD_READY);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_idle;
        logic [255:0] got;
        logic [255:0] e;
        int ns;
        int per;
        bit ok;
        en = 1'b1;
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back(exp_frame(0, '0, '0, 0, '0, '0));
            grab(0, got, ns, ok);
            if (ok) begin
                e = exp_q.pop_front();
                checks++;
                if (got !== e) begin
                    failures++;
                    $display("FAIL idle_frame got=%h required=%h", got, e);
                end
                checks++;
                if (ns != 16) begin
                    failures++;
                    $display("FAIL idle_sync_len got=%0d required=16", ns);
                end
            end
        end
        wait_start(ok);
        per = 0;
        if (ok) begin
            for (int i = 0; i < 600; i++) begin
                @(negedge clk);
                per++;
                if (fstart === 1'b1) break;
            end
            checks++;
            if (per != 256) begin
                failures++;
                $display("FAIL frame_period got=%0d required=256", per);
            end
        end
    endtask

    task automatic test_sample;
        logic [255:0] got;
        logic [255:0] e;
        logic [15:0] tag;
        int ns;
        bit ok;
        wait_start(ok);
        send_sample(20'hABCDE, 20'h12345);
        checks++;
        if (bus.O_SAMPLE_READY !== 1'b0) begin
            failures++;
            $display("FAIL sample_ready_low got=%b required=0",
                     bus.O_SAMPLE_READY);
        end
        exp_q.push_back(exp_frame(1, 20'hABCDE, 20'h12345, 0, '0, '0));
        exp_q.push_back(exp_frame(0, '0, '0, 0, '0, '0));
        grab(0, got, ns, ok);
        if (ok) begin
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL sample_frame got=%h required=%h", got, e);
            end
            for (int k = 0; k < 16; k++) tag[15 - k] = got[k];
            checks++;
            if (tag !== 16'b1001_1000_0000_0000) begin
                failures++;
                $display("FAIL sample_tag got=%b required=%b", tag,
                         16'b1001_1000_0000_0000);
            end
        end
        grab(0, got, ns, ok);
        if (ok) begin
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL sample_next_frame got=%h required=%h", got, e);
            end
        end
    endtask

    task automatic test_cmd;
        logic [255:0] got;
        logic [255:0] e;
        logic [15:0] tag;
        int ns;
        bit ok;
        wait_start(ok);
        bus.I_CMD_VALID = 1'b1;
        bus.I_CMD_ADDR = 7'h02;
        bus.I_CMD_DATA = 16'h0808;
        @(negedge clk);
        bus.I_CMD_VALID = 1'b0;
        exp_q.push_back(exp_frame(0, '0, '0, 1, 7'h02, 16'h0808));
        checks++;
        if (bus.O_CMD_READY !== 1'b0) begin
            failures++;
            $display("FAIL cmd_ready_low got=%b required=0", bus.O_CMD_READY);
        end
        repeat (254) @(negedge clk);
        checks++;
        if (bus.O_CMD_READY !== 1'b0) begin
            failures++;
            $display("FAIL cmd_ready_before_load got=%b required=0",
                     bus.O_CMD_READY);
        end
        wait_start(ok);
        if (ok) begin
            checks++;
            if (bus.O_CMD_READY !== 1'b1) begin
                failures++;
                $display("FAIL cmd_ready_after_load got=%b required=1",
                         bus.O_CMD_READY);
            end
            grab(1, got, ns, ok);
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL cmd_frame got=%h required=%h", got, e);
            end
            for (int k = 0; k < 16; k++) tag[15 - k] = got[k];
            checks++;
            if (tag !== 16'b1110_0000_0000_0000) begin
                failures++;
                $display("FAIL cmd_tag got=%b required=%b", tag,
                         16'b1110_0000_0000_0000);
            end
        end
    endtask

    task automatic test_back_to_back;
        bit ok;
        wait_start(ok);
        fork
            begin
                int n;
                int lows;
                n = 0;
                lows = 0;
                bus.I_LEFT = 20'($urandom());
                bus.I_RIGHT = 20'($urandom());
                bus.I_SAMPLE_VALID = 1'b1;
                for (int c = 0; c < 2000 && n < 3; c++) begin
                    if (bus.O_SAMPLE_READY === 1'b1) begin
                        @(posedge clk);
                        #1;
                        exp_q.push_back(exp_frame(1, bus.I_LEFT, bus.I_RIGHT,
                                                  0, '0, '0));
                        n++;
                        if (n > 1) begin
                            checks++;
                            if (lows != 255) begin
                                failures++;
                                $display("FAIL b2b_ready_low got=%0d required=255",
                                         lows);
                            end
                        end
                        lows = 0;
                        bus.I_LEFT = 20'($urandom());
                        bus.I_RIGHT = 20'($urandom());
                    end else begin
                        lows++;
                    end
                    @(negedge clk);
                end
                bus.I_SAMPLE_VALID = 1'b0;
                checks++;
                if (n != 3) begin
                    failures++;
                    $display("FAIL b2b_transfers got=%0d required=3", n);
                end
            end
            begin
                logic [255:0] got;
                logic [255:0] e;
                int ns;
                bit gok;
                for (int k = 0; k < 3; k++) begin
                    grab(0, got, ns, gok);
                    checks++;
                    if (!gok || exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL b2b_frame_missing got=none required=frame");
                    end else begin
                        e = exp_q.pop_front();
                        if (got !== e) begin
                            failures++;
                            $display("FAIL b2b_frame got=%h required=%h", got, e);
                        end
                    end
                end
            end
        join
    endtask

    task automatic test_enable_gap;
        logic [255:0] got;
        logic [255:0] e;
        int ns;
        int bad;
        bit ok;
        wait_start(ok);
        send_sample(20'h5A5A5, 20'hC3C3C);
        repeat (99) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        checks++;
        if ({sync, sdata, fstart} !== 3'b000) begin
            failures++;
            $display("FAIL disable_outputs got=%b required=000",
                     {sync, sdata, fstart});
        end
        bad = 0;
        repeat (300) begin
            @(negedge clk);
            if ({sync, sdata, fstart} !== 3'b000) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL disable_idle got=%0d required=0", bad);
        end
        checks++;
        if (bus.O_SAMPLE_READY !== 1'b0) begin
            failures++;
            $display("FAIL disable_hold got=%b required=0",
                     bus.O_SAMPLE_READY);
        end
        exp_q.push_back(exp_frame(1, 20'h5A5A5, 20'hC3C3C, 0, '0, '0));
        en = 1'b1;
        @(negedge clk);
        checks++;
        if ({fstart, sync} !== 2'b11) begin
            failures++;
            $display("FAIL reenable_first got=%b required=11", {fstart, sync});
        end
        grab(1, got, ns, ok);
        e = exp_q.pop_front();
        checks++;
        if (got !== e) begin
            failures++;
            $display("FAIL reenable_frame got=%h required=%h", got, e);
        end
    endtask

    task automatic test_reset_mid;
        logic [255:0] got;
        logic [255:0] e;
        int ns;
        bit ok;
        wait_start(ok);
        send_sample(20'hFFFFF, 20'h00001);
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({sync, sdata, fstart} !== 3'b000) begin
            failures++;
            $display("FAIL midreset_outputs got=%b required=000",
                     {sync, sdata, fstart});
        end
        checks++;
        if (bus.O_SAMPLE_READY !== 1'b1) begin
            failures++;
            $display("FAIL midreset_sready got=%b required=1",
                     bus.O_SAMPLE_READY);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(exp_frame(0, '0, '0, 0, '0, '0));
        grab(0, got, ns, ok);
        if (ok) begin
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL midreset_frame got=%h required=%h", got, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_sample();
        test_cmd();
        test_back_to_back();
        test_enable_gap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
